// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb: round-robin arbiter sharing one EASYAXI slave read port (AR+R)
// among N_MST read masters. One burst in flight at a time: IDLE picks a master,
// ADDR forwards its AR, DATA routes R beats back until the RLAST handshake.
// Optional feature macro: EASYAXI_ARB_STAT_EN adds per-master AR grant counters
// on output arb_gnt_cnt (16 bits per master, saturating).

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_arb #(
  parameter int N_MST = 4,
  parameter int GNT_W = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  // master-side AR
  input  logic [N_MST-1:0]                mst_arvalid,
  output logic [N_MST-1:0]                mst_arready,
  input  logic [N_MST*`AXI_ID_W-1:0]      mst_arid,
  input  logic [N_MST*`AXI_ADDR_W-1:0]    mst_araddr,
  input  logic [N_MST*`AXI_LEN_W-1:0]     mst_arlen,
  input  logic [N_MST*`AXI_SIZE_W-1:0]    mst_arsize,
  input  logic [N_MST*`AXI_BURST_W-1:0]   mst_arburst,
  // master-side R
  output logic [N_MST-1:0]                mst_rvalid,
  input  logic [N_MST-1:0]                mst_rready,
  output logic [`AXI_DATA_W-1:0]          mst_rdata,
  output logic [`AXI_RESP_W-1:0]          mst_rresp,
  output logic                            mst_rlast,
  // slave-side AR
  output logic                            slv_arvalid,
  input  logic                            slv_arready,
  output logic [`AXI_ID_W-1:0]            slv_arid,
  output logic [`AXI_ADDR_W-1:0]          slv_araddr,
  output logic [`AXI_LEN_W-1:0]           slv_arlen,
  output logic [`AXI_SIZE_W-1:0]          slv_arsize,
  output logic [`AXI_BURST_W-1:0]         slv_arburst,
  // slave-side R
  input  logic                            slv_rvalid,
  output logic                            slv_rready,
  input  logic [`AXI_DATA_W-1:0]          slv_rdata,
  input  logic [`AXI_RESP_W-1:0]          slv_rresp,
  input  logic                            slv_rlast,
  // status
  output logic                            arb_busy,
`ifdef EASYAXI_ARB_STAT_EN
  output logic [N_MST*16-1:0]             arb_gnt_cnt,
`endif
  output logic [GNT_W-1:0]                arb_gnt
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t           state, state_nxt;
  logic [GNT_W-1:0] gnt, rr_ptr, pick, gnt_inc;
  logic [GNT_W:0]   idx;
  logic             found, ar_hs, r_done;

  // Round-robin search: first requester at rr_ptr, rr_ptr+1, ... wrapping at N_MST.
  // idx is one bit wider so the wrap works for non-power-of-2 N_MST.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_MST; k++) begin
      idx = {1'b0, rr_ptr} + (GNT_W+1)'(k);
      if (idx >= (GNT_W+1)'(N_MST)) idx = idx - (GNT_W+1)'(N_MST);
      if (!found && mst_arvalid[idx[GNT_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[GNT_W-1:0];
      end
    end
  end

  assign gnt_inc = (gnt == GNT_W'(N_MST-1)) ? '0 : gnt + 1'b1;
  assign ar_hs   = (state == S_ADDR) && mst_arvalid[gnt] && slv_arready;
  assign r_done  = (state == S_DATA) && slv_rvalid && mst_rready[gnt] && slv_rlast;

  // Next-state: one burst at a time, one IDLE bubble between bursts.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable && found) state_nxt = S_ADDR;
      S_ADDR:  if (ar_hs)           state_nxt = S_DATA;
      S_DATA:  if (r_done)          state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // State, grant index and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && enable && found) gnt <= pick;
      if (r_done) rr_ptr <= gnt_inc;
    end
  end

  // Handshake routing: only the granted master sees ready/valid, and only in its phase.
  always_comb begin
    slv_arvalid = 1'b0;
    mst_arready = '0;
    mst_rvalid  = '0;
    slv_rready  = 1'b0;
    case (state)
      S_ADDR: begin
        slv_arvalid      = mst_arvalid[gnt];
        mst_arready[gnt] = slv_arready;
      end
      S_DATA: begin
        mst_rvalid[gnt] = slv_rvalid;
        slv_rready      = mst_rready[gnt];
      end
      default: ;
    endcase
  end

  // AR payload mux from the granted master.
  always_comb begin
    slv_arid    = '0;
    slv_araddr  = '0;
    slv_arlen   = '0;
    slv_arsize  = '0;
    slv_arburst = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (gnt == GNT_W'(i)) begin
        slv_arid    = mst_arid   [i*`AXI_ID_W    +: `AXI_ID_W];
        slv_araddr  = mst_araddr [i*`AXI_ADDR_W  +: `AXI_ADDR_W];
        slv_arlen   = mst_arlen  [i*`AXI_LEN_W   +: `AXI_LEN_W];
        slv_arsize  = mst_arsize [i*`AXI_SIZE_W  +: `AXI_SIZE_W];
        slv_arburst = mst_arburst[i*`AXI_BURST_W +: `AXI_BURST_W];
      end
    end
  end

  // R payload is broadcast; mst_rvalid alone qualifies it.
  assign mst_rdata = slv_rdata;
  assign mst_rresp = slv_rresp;
  assign mst_rlast = slv_rlast;
  assign arb_busy  = (state != S_IDLE);
  assign arb_gnt   = gnt;

`ifdef EASYAXI_ARB_STAT_EN
  logic [N_MST-1:0][15:0] gnt_cnt;

  for (genvar g = 0; g < N_MST; g++) begin : g_cnt
    // Count AR handshakes of master g, saturating at all-ones.
    always_ff @(posedge clk) begin
      if (rst)
        gnt_cnt[g] <= '0;
      else if (ar_hs && gnt == GNT_W'(g) && gnt_cnt[g] != 16'hFFFF)
        gnt_cnt[g] <= gnt_cnt[g] + 16'd1;
    end
  end

  assign arb_gnt_cnt = gnt_cnt;
`endif

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Testbench for easyaxi_rd_arb: directed scenarios plus a randomized run checked
// against a transaction-level model (owner / pointer / beat bookkeeping).

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_arb;
  localparam int N   = 4;
  localparam int GW  = 2;
  localparam int IDW = `AXI_ID_W;
  localparam int AW  = `AXI_ADDR_W;
  localparam int LW  = `AXI_LEN_W;
  localparam int SW  = `AXI_SIZE_W;
  localparam int BW  = `AXI_BURST_W;
  localparam int DW  = `AXI_DATA_W;
  localparam int RW  = `AXI_RESP_W;

  logic clk = 1'b0, rst, enable;
  logic [N-1:0] mst_arvalid, mst_arready, mst_rvalid, mst_rready;
  logic [N*IDW-1:0] mst_arid;
  logic [N*AW-1:0] mst_araddr;
  logic [N*LW-1:0] mst_arlen;
  logic [N*SW-1:0] mst_arsize;
  logic [N*BW-1:0] mst_arburst;
  logic [DW-1:0] mst_rdata, slv_rdata;
  logic [RW-1:0] mst_rresp, slv_rresp;
  logic mst_rlast, slv_arvalid, slv_arready, slv_rvalid, slv_rready, slv_rlast, arb_busy;
  logic [IDW-1:0] slv_arid;
  logic [AW-1:0] slv_araddr;
  logic [LW-1:0] slv_arlen;
  logic [SW-1:0] slv_arsize;
  logic [BW-1:0] slv_arburst;
  logic [GW-1:0] arb_gnt;
`ifdef EASYAXI_ARB_STAT_EN
  logic [N*16-1:0] arb_gnt_cnt;
`endif

  logic [IDW-1:0] p_id [N];
  logic [AW-1:0]  p_addr [N];
  logic [LW-1:0]  p_len [N];
  logic [SW-1:0]  p_size [N];
  logic [BW-1:0]  p_burst [N];

  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mst_arid   [i*IDW +: IDW] = p_id[i];
      mst_araddr [i*AW  +: AW]  = p_addr[i];
      mst_arlen  [i*LW  +: LW]  = p_len[i];
      mst_arsize [i*SW  +: SW]  = p_size[i];
      mst_arburst[i*BW  +: BW]  = p_burst[i];
    end
  end

  easyaxi_rd_arb #(.N_MST(N), .GNT_W(GW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_arid(mst_arid),
    .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
    .mst_arburst(mst_arburst), .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
    .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
    .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_arid(slv_arid),
    .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
    .slv_arburst(slv_arburst), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
    .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rlast(slv_rlast),
    .arb_busy(arb_busy),
`ifdef EASYAXI_ARB_STAT_EN
    .arb_gnt_cnt(arb_gnt_cnt),
`endif
    .arb_gnt(arb_gnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1;
    mst_arvalid = '0; mst_rready = '0;
    slv_arready = 1'b0; slv_rvalid = 1'b0; slv_rlast = 1'b0;
    slv_rdata = '0; slv_rresp = '0;
    for (int i = 0; i < N; i++) begin
      p_id[i] = '0; p_addr[i] = '0; p_len[i] = '0; p_size[i] = '0; p_burst[i] = '0;
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    slv_arready = 1'b1; slv_rvalid = 1'b1; mst_rready = '1; slv_rdata = DW'(32'h1234_5678);
    #1;
    vecs++; if (arb_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%0h exp=0", arb_busy); end
    vecs++; if (arb_gnt !== '0) begin errs++; $display("FAIL reset_gnt got=%0h exp=0", arb_gnt); end
    vecs++; if (slv_arvalid !== 1'b0 || mst_arready !== '0) begin errs++; $display("FAIL reset_ar got=%0h/%0h exp=0/0", slv_arvalid, mst_arready); end
    vecs++; if (mst_rvalid !== '0 || slv_rready !== 1'b0) begin errs++; $display("FAIL reset_r got=%0h/%0h exp=0/0", mst_rvalid, slv_rready); end
    vecs++; if (mst_rdata !== DW'(32'h1234_5678)) begin errs++; $display("FAIL reset_rdata_bcast got=%0h exp=12345678", mst_rdata); end
    slv_rvalid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    p_addr[1] = AW'(32'h40); p_len[1] = LW'(3); p_id[1] = IDW'(5); p_size[1] = SW'(2); p_burst[1] = BW'(1);
    slv_arready = 1'b1; mst_rready = '1; mst_arvalid = 4'b0010;
    #1;
    vecs++; if (slv_arvalid !== 1'b0) begin errs++; $display("FAIL single_idle_arvalid got=%0h exp=0", slv_arvalid); end
    tick();
    vecs++; if (slv_arvalid !== 1'b1 || slv_araddr !== AW'(32'h40)) begin errs++; $display("FAIL single_ar got=%0h/%0h exp=1/40", slv_arvalid, slv_araddr); end
    vecs++; if (slv_arlen !== LW'(3) || slv_arid !== IDW'(5) || slv_arsize !== SW'(2) || slv_arburst !== BW'(1)) begin
      errs++; $display("FAIL single_payload got=%0h/%0h/%0h/%0h exp=3/5/2/1", slv_arlen, slv_arid, slv_arsize, slv_arburst); end
    vecs++; if (mst_arready !== 4'b0010 || arb_gnt !== GW'(1)) begin errs++; $display("FAIL single_gnt got=%0h/%0h exp=2/1", mst_arready, arb_gnt); end
    tick();
    mst_arvalid = '0;
    for (int b = 0; b < 4; b++) begin
      slv_rvalid = 1'b1; slv_rdata = DW'(32'hD000 + b); slv_rlast = (b == 3);
      #1;
      vecs++; if (mst_rvalid !== 4'b0010 || slv_rready !== 1'b1) begin errs++; $display("FAIL single_beat%0d got=%0h/%0h exp=2/1", b, mst_rvalid, slv_rready); end
      vecs++; if (mst_rdata !== DW'(32'hD000 + b) || mst_rlast !== (b == 3)) begin errs++; $display("FAIL single_data%0d got=%0h/%0h", b, mst_rdata, mst_rlast); end
      tick();
    end
    slv_rvalid = 1'b0; slv_rlast = 1'b0;
    #1;
    vecs++; if (arb_busy !== 1'b0) begin errs++; $display("FAIL single_busy_fall got=%0h exp=0", arb_busy); end
  endtask

  task automatic test_fairness();
    int exp_g, nhs, last;
    do_reset();
    mst_arvalid = '1; slv_arready = 1'b1; slv_rvalid = 1'b1; slv_rlast = 1'b1; mst_rready = '1;
    exp_g = 0; nhs = 0; last = 0;
    for (int cyc = 0; cyc < 40 && nhs < 6; cyc++) begin
      #1;
      if (slv_arvalid && slv_arready) begin
        vecs++; if (arb_gnt !== GW'(exp_g) || mst_arready !== N'(1 << exp_g)) begin
          errs++; $display("FAIL fair_order%0d got=%0h/%0h exp gnt=%0h", nhs, arb_gnt, mst_arready, exp_g); end
        if (nhs > 0) begin
          vecs++; if (cyc - last != 3) begin errs++; $display("FAIL fair_period got=%0d exp=3", cyc - last); end
        end
        last = cyc; exp_g = (exp_g + 1) % N; nhs++;
      end
      tick();
    end
    vecs++; if (nhs != 6) begin errs++; $display("FAIL fair_count got=%0d exp=6", nhs); end
    mst_arvalid = '0; slv_rvalid = 1'b0; slv_rlast = 1'b0;
  endtask

  task automatic test_backpressure();
    int b;
    logic rr;
    do_reset();
    p_len[2] = LW'(3); p_len[3] = LW'(0);
    mst_arvalid = 4'b1100; slv_arready = 1'b0; mst_rready = 4'b1011;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      vecs++; if (slv_arvalid !== 1'b1 || arb_gnt !== GW'(2) || mst_arready !== '0) begin
        errs++; $display("FAIL bp_addr_wait%0d got=%0h/%0h/%0h exp=1/2/0", k, slv_arvalid, arb_gnt, mst_arready); end
      tick();
    end
    slv_arready = 1'b1;
    #1;
    vecs++; if (mst_arready !== 4'b0100) begin errs++; $display("FAIL bp_arready got=%0h exp=4", mst_arready); end
    tick();
    mst_arvalid[2] = 1'b0; slv_arready = 1'b0;
    b = 0; rr = 1'b0;
    for (int cyc = 0; cyc < 20 && b < 4; cyc++) begin
      mst_rready[2] = rr; slv_rvalid = 1'b1; slv_rdata = DW'(32'hB0 + b); slv_rlast = (b == 3);
      #1;
      vecs++; if (mst_rvalid !== 4'b0100 || slv_rready !== rr) begin
        errs++; $display("FAIL bp_route got=%0h/%0h exp=4/%0h", mst_rvalid, slv_rready, rr); end
      if (rr) begin
        vecs++; if (mst_rdata !== DW'(32'hB0 + b)) begin errs++; $display("FAIL bp_beat got=%0h exp=%0h", mst_rdata, 32'hB0 + b); end
        b++;
      end
      rr = !rr;
      tick();
    end
    vecs++; if (b != 4) begin errs++; $display("FAIL bp_beats got=%0d exp=4", b); end
    slv_rvalid = 1'b0; slv_rlast = 1'b0;
    #1;
    vecs++; if (arb_busy !== 1'b0) begin errs++; $display("FAIL bp_bubble got=%0h exp=0", arb_busy); end
    tick();
    vecs++; if (arb_gnt !== GW'(3) || slv_arvalid !== 1'b1) begin errs++; $display("FAIL bp_next got=%0h/%0h exp=3/1", arb_gnt, slv_arvalid); end
  endtask

  task automatic test_enable();
    do_reset();
    p_len[0] = LW'(1);
    mst_arvalid = 4'b1001; slv_arready = 1'b1; mst_rready = '1;
    tick();
    vecs++; if (arb_gnt !== GW'(0)) begin errs++; $display("FAIL en_first got=%0h exp=0", arb_gnt); end
    tick();
    mst_arvalid[0] = 1'b0; enable = 1'b0;
    for (int b = 0; b < 2; b++) begin
      slv_rvalid = 1'b1; slv_rlast = (b == 1);
      #1;
      vecs++; if (mst_rvalid !== 4'b0001) begin errs++; $display("FAIL en_beat%0d got=%0h exp=1", b, mst_rvalid); end
      tick();
    end
    slv_rvalid = 1'b0; slv_rlast = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vecs++; if (arb_busy !== 1'b0 || slv_arvalid !== 1'b0) begin errs++; $display("FAIL en_hold%0d got=%0h/%0h exp=0/0", k, arb_busy, slv_arvalid); end
      tick();
    end
    enable = 1'b1;
    tick();
    vecs++; if (arb_busy !== 1'b1 || arb_gnt !== GW'(3) || slv_arvalid !== 1'b1) begin
      errs++; $display("FAIL en_resume got=%0h/%0h/%0h exp=1/3/1", arb_busy, arb_gnt, slv_arvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    p_len[1] = LW'(3);
    mst_arvalid = 4'b0010; slv_arready = 1'b1; mst_rready = '1;
    tick(); tick();
    mst_arvalid = '0;
    slv_rvalid = 1'b1; slv_rlast = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vecs++; if (arb_busy !== 1'b0 || arb_gnt !== '0) begin errs++; $display("FAIL rstmid_state got=%0h/%0h exp=0/0", arb_busy, arb_gnt); end
    vecs++; if (mst_rvalid !== '0 || slv_rready !== 1'b0 || slv_arvalid !== 1'b0 || mst_arready !== '0) begin
      errs++; $display("FAIL rstmid_hs got=%0h/%0h/%0h/%0h exp=0", mst_rvalid, slv_rready, slv_arvalid, mst_arready); end
    slv_rvalid = 1'b0;
  endtask

`ifdef EASYAXI_ARB_STAT_EN
  task automatic test_stat();
    int seq [5] = '{1, 1, 2, 1, 2};
    do_reset();
    #1;
    vecs++; if (arb_gnt_cnt !== '0) begin errs++; $display("FAIL stat_reset got=%0h exp=0", arb_gnt_cnt); end
    slv_arready = 1'b1; slv_rvalid = 1'b1; slv_rlast = 1'b1; mst_rready = '1;
    for (int k = 0; k < 5; k++) begin
      mst_arvalid = N'(1 << seq[k]);
      tick(); tick();
      mst_arvalid = '0;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      vecs++; if (arb_gnt_cnt[i*16 +: 16] !== 16'((i == 1) ? 3 : (i == 2) ? 2 : 0)) begin
        errs++; $display("FAIL stat_cnt%0d got=%0d", i, arb_gnt_cnt[i*16 +: 16]); end
    end
    slv_rvalid = 1'b0; slv_rlast = 1'b0;
  endtask
`endif

  task automatic test_random();
    int owner, ptr, s_left;
    bit ar_done, picked;
    int stat [N];
    logic [N-1:0] pend, exp_ar, exp_rv;
    logic exp_arv, exp_rr, ar_hs, r_hs;
    do_reset();
    owner = -1; ptr = 0; ar_done = 0; s_left = 0; pend = '0;
    for (int i = 0; i < N; i++) stat[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          p_id[i] = IDW'($urandom); p_addr[i] = AW'($urandom); p_len[i] = LW'($urandom_range(0, 3));
          p_size[i] = SW'($urandom); p_burst[i] = BW'($urandom);
        end
      end
      mst_arvalid = pend;
      mst_rready  = N'($urandom);
      enable      = ($urandom_range(0, 7) != 0);
      slv_arready = 1'($urandom_range(0, 1));
      slv_rvalid  = (s_left > 0) && ($urandom_range(0, 1) == 1);
      slv_rlast   = (s_left == 1);
      slv_rdata   = DW'($urandom); slv_rresp = RW'($urandom);
      #1;
      exp_arv = 1'b0; exp_ar = '0; exp_rv = '0; exp_rr = 1'b0;
      if (owner >= 0 && !ar_done) begin exp_arv = pend[owner]; exp_ar[owner] = slv_arready; end
      if (owner >= 0 && ar_done) begin exp_rv[owner] = slv_rvalid; exp_rr = mst_rready[owner]; end
      vecs++; if (arb_busy !== (owner >= 0)) begin errs++; $display("FAIL rnd_busy c%0d got=%0h exp=%0h", cyc, arb_busy, owner >= 0); end
      if (owner >= 0) begin
        vecs++; if (arb_gnt !== GW'(owner)) begin errs++; $display("FAIL rnd_gnt c%0d got=%0h exp=%0h", cyc, arb_gnt, owner); end
      end
      vecs++; if (slv_arvalid !== exp_arv || mst_arready !== exp_ar) begin
        errs++; $display("FAIL rnd_ar c%0d got=%0h/%0h exp=%0h/%0h", cyc, slv_arvalid, mst_arready, exp_arv, exp_ar); end
      vecs++; if (mst_rvalid !== exp_rv || slv_rready !== exp_rr) begin
        errs++; $display("FAIL rnd_r c%0d got=%0h/%0h exp=%0h/%0h", cyc, mst_rvalid, slv_rready, exp_rv, exp_rr); end
      if (exp_arv) begin
        vecs++; if (slv_araddr !== p_addr[owner] || slv_arid !== p_id[owner] || slv_arlen !== p_len[owner]) begin
          errs++; $display("FAIL rnd_payload c%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, slv_araddr, slv_arid, slv_arlen,
                           p_addr[owner], p_id[owner], p_len[owner]); end
      end
      vecs++; if (mst_rdata !== slv_rdata || mst_rresp !== slv_rresp || mst_rlast !== slv_rlast) begin
        errs++; $display("FAIL rnd_bcast c%0d got=%0h exp=%0h", cyc, mst_rdata, slv_rdata); end
      ar_hs = slv_arvalid && slv_arready;
      r_hs  = slv_rvalid && slv_rready;
      // reference model update
      if (owner < 0) begin
        if (enable && |pend) begin
          picked = 0;
          for (int k = 0; k < N; k++) begin
            if (!picked && pend[(ptr + k) % N]) begin owner = (ptr + k) % N; picked = 1; end
          end
          ar_done = 0;
        end
      end else if (!ar_done) begin
        if (pend[owner] && slv_arready) begin ar_done = 1; stat[owner]++; end
      end else if (slv_rvalid && mst_rready[owner] && slv_rlast) begin
        ptr = (owner + 1) % N; owner = -1;
      end
      // master and slave agents
      for (int i = 0; i < N; i++) if (pend[i] && mst_arready[i]) pend[i] = 1'b0;
      if (ar_hs) s_left = int'(slv_arlen) + 1;
      else if (r_hs) s_left--;
      tick();
    end
`ifdef EASYAXI_ARB_STAT_EN
    for (int i = 0; i < N; i++) begin
      vecs++; if (arb_gnt_cnt[i*16 +: 16] !== 16'(stat[i])) begin
        errs++; $display("FAIL rnd_stat%0d got=%0d exp=%0d", i, arb_gnt_cnt[i*16 +: 16], stat[i]); end
    end
`endif
    mst_arvalid = '0; slv_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_enable();
    test_reset_mid();
`ifdef EASYAXI_ARB_STAT_EN
    test_stat();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
